// File: rtl/xadac_vrf_seq_if.sv
// Bundle of issue, VRF, exe and completion signals around the xadac VRF sequencer.
// master = sequencer side, slave = issue stage / VRF / exe slave side.
interface xadac_vrf_seq_if #(
  parameter int VecDataWidth = 128,
  parameter int NumVecRegs   = 32,
  parameter int IdWidth      = 4,
  parameter int InstrWidth   = 32
);
  localparam int AddrWidth = $clog2(NumVecRegs);

  logic                    issue_valid;
  logic                    issue_ready;
  logic [IdWidth-1:0]      issue_id;
  logic [InstrWidth-1:0]   issue_instr;

  logic                    vrf_ren;
  logic [AddrWidth-1:0]    vrf_raddr;
  logic [VecDataWidth-1:0] vrf_rdata;
  logic                    vrf_we;
  logic [AddrWidth-1:0]    vrf_waddr;
  logic [VecDataWidth-1:0] vrf_wdata;

  logic                    exe_req_valid;
  logic                    exe_req_ready;
  logic [IdWidth-1:0]      exe_req_id;
  logic [InstrWidth-1:0]   exe_req_instr;
  logic [VecDataWidth-1:0] exe_req_vs0;
  logic [VecDataWidth-1:0] exe_req_vs1;
  logic [VecDataWidth-1:0] exe_req_vs2;

  logic                    exe_rsp_valid;
  logic                    exe_rsp_ready;
  logic [IdWidth-1:0]      exe_rsp_id;
  logic [AddrWidth-1:0]    exe_rsp_vd_addr;
  logic [VecDataWidth-1:0] exe_rsp_vd_data;
  logic                    exe_rsp_vd_write;

  logic                    done_valid;
  logic [IdWidth-1:0]      done_id;
  logic                    id_err;

  modport master (
    input  issue_valid, issue_id, issue_instr, vrf_rdata, exe_req_ready,
           exe_rsp_valid, exe_rsp_id, exe_rsp_vd_addr, exe_rsp_vd_data, exe_rsp_vd_write,
    output issue_ready, vrf_ren, vrf_raddr, vrf_we, vrf_waddr, vrf_wdata,
           exe_req_valid, exe_req_id, exe_req_instr, exe_req_vs0, exe_req_vs1, exe_req_vs2,
           exe_rsp_ready, done_valid, done_id, id_err
  );

  modport slave (
    output issue_valid, issue_id, issue_instr, vrf_rdata, exe_req_ready,
           exe_rsp_valid, exe_rsp_id, exe_rsp_vd_addr, exe_rsp_vd_data, exe_rsp_vd_write,
    input  issue_ready, vrf_ren, vrf_raddr, vrf_we, vrf_waddr, vrf_wdata,
           exe_req_valid, exe_req_id, exe_req_instr, exe_req_vs0, exe_req_vs1, exe_req_vs2,
           exe_rsp_ready, done_valid, done_id, id_err
  );
endinterface

// File: rtl/xadac_vrf_seq.sv
// Operand-fetch / write-back sequencer in front of the xadac vector exe slaves.
// Optional perf counters are enabled by defining XADAC_VRF_SEQ_PERF_EN.
module xadac_vrf_seq #(
  parameter int VecDataWidth = 128,
  parameter int NumVecRegs   = 32,
  parameter int IdWidth      = 4,
  parameter int InstrWidth   = 32
) (
  input logic clk,
  input logic rstn,
  xadac_vrf_seq_if.master bus
`ifdef XADAC_VRF_SEQ_PERF_EN
  ,
  output logic [31:0] perf_instr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int AddrWidth = $clog2(NumVecRegs);

  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RDL, S_EXE, S_RSP, S_WB
  } state_e;

  state_e state, state_next;

  logic [IdWidth-1:0]      id_q;
  logic [InstrWidth-1:0]   instr_q;
  logic [VecDataWidth-1:0] vs0_q, vs1_q, vs2_q;
  logic [AddrWidth-1:0]    rsp_addr_q;
  logic [VecDataWidth-1:0] rsp_data_q;
  logic                    rsp_write_q;
  logic                    id_err_q;

  logic                    issue_ready, vrf_ren, vrf_we;
  logic                    exe_req_valid, exe_rsp_ready, done_valid;
  logic [AddrWidth-1:0]    vrf_raddr;
  logic                    latch_rsp;

  logic [AddrWidth-1:0]    rs1_addr, rs2_addr, vd_addr;

  // Operand fields: vs0 <- rs1, vs1 <- rs2, vs2 (accumulator) <- vd.
  assign rs1_addr = instr_q[15 +: AddrWidth];
  assign rs2_addr = instr_q[20 +: AddrWidth];
  assign vd_addr  = instr_q[7 +: AddrWidth];

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    issue_ready   = 1'b0;
    vrf_ren       = 1'b0;
    vrf_raddr     = '0;
    vrf_we        = 1'b0;
    exe_req_valid = 1'b0;
    exe_rsp_ready = 1'b0;
    done_valid    = 1'b0;
    latch_rsp     = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = rstn;
        if (bus.issue_valid) state_next = S_RD0;
      end
      S_RD0: begin
        vrf_ren    = 1'b1;
        vrf_raddr  = rs1_addr;
        state_next = S_RD1;
      end
      S_RD1: begin
        vrf_ren    = 1'b1;
        vrf_raddr  = rs2_addr;
        state_next = S_RD2;
      end
      S_RD2: begin
        vrf_ren    = 1'b1;
        vrf_raddr  = vd_addr;
        state_next = S_RDL;
      end
      S_RDL: state_next = S_EXE;
      S_EXE: begin
        // rsp_ready is offered here too so combinational slaves cannot deadlock.
        exe_req_valid = 1'b1;
        exe_rsp_ready = 1'b1;
        if (bus.exe_req_ready && bus.exe_rsp_valid) begin
          latch_rsp  = 1'b1;
          state_next = S_WB;
        end else if (bus.exe_req_ready) begin
          state_next = S_RSP;
        end
      end
      S_RSP: begin
        exe_rsp_ready = 1'b1;
        if (bus.exe_rsp_valid) begin
          latch_rsp  = 1'b1;
          state_next = S_WB;
        end
      end
      S_WB: begin
        vrf_we     = rsp_write_q;
        done_valid = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand / response capture; VRF read data arrives one cycle after each read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      id_q        <= '0;
      instr_q     <= '0;
      vs0_q       <= '0;
      vs1_q       <= '0;
      vs2_q       <= '0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      id_err_q    <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.issue_valid) begin
        id_q    <= bus.issue_id;
        instr_q <= bus.issue_instr;
      end
      if (state == S_RD1) vs0_q <= bus.vrf_rdata;
      if (state == S_RD2) vs1_q <= bus.vrf_rdata;
      if (state == S_RDL) vs2_q <= bus.vrf_rdata;
      if (latch_rsp) begin
        rsp_addr_q  <= bus.exe_rsp_vd_addr;
        rsp_data_q  <= bus.exe_rsp_vd_data;
        rsp_write_q <= bus.exe_rsp_vd_write;
        if (bus.exe_rsp_id != id_q) id_err_q <= 1'b1;
      end
    end
  end

`ifdef XADAC_VRF_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (done_valid) perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if ((state == S_EXE && !bus.exe_req_ready) || (state == S_RSP && !bus.exe_rsp_valid))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  assign bus.issue_ready   = issue_ready;
  assign bus.vrf_ren       = vrf_ren;
  assign bus.vrf_raddr     = vrf_raddr;
  assign bus.vrf_we        = vrf_we;
  assign bus.vrf_waddr     = rsp_addr_q;
  assign bus.vrf_wdata     = rsp_data_q;
  assign bus.exe_req_valid = exe_req_valid;
  assign bus.exe_req_id    = id_q;
  assign bus.exe_req_instr = instr_q;
  assign bus.exe_req_vs0   = vs0_q;
  assign bus.exe_req_vs1   = vs1_q;
  assign bus.exe_req_vs2   = vs2_q;
  assign bus.exe_rsp_ready = exe_rsp_ready;
  assign bus.done_valid    = done_valid;
  assign bus.done_id       = id_q;
  assign bus.id_err        = id_err_q;
endmodule

// File: tb/tb_xadac_vrf_seq.sv
// Directed bench for xadac_vrf_seq with a behavioural VRF and hand-driven exe slave.
// Perf counter checks are included when XADAC_VRF_SEQ_PERF_EN is defined.
`timescale 1ns/1ps
module tb_xadac_vrf_seq;
  localparam int VW = 128;
  localparam int NR = 32;
  localparam int IW = 4;
  localparam int INW = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic preload = 1'b0;
  int checks = 0;
  int errors = 0;
  int we_count = 0;
  int done_count = 0;
  logic [VW-1:0] vrf_mem [NR];

  always #5 clk = ~clk;

  xadac_vrf_seq_if #(.VecDataWidth(VW), .NumVecRegs(NR), .IdWidth(IW), .InstrWidth(INW)) bus ();

`ifdef XADAC_VRF_SEQ_PERF_EN
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

  xadac_vrf_seq #(.VecDataWidth(VW), .NumVecRegs(NR), .IdWidth(IW), .InstrWidth(INW)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
`ifdef XADAC_VRF_SEQ_PERF_EN
    ,
    .perf_instr_cnt(perf_instr_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  function automatic logic [VW-1:0] fill(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] vd);
    return {7'h00, rs2, rs1, 3'b000, vd, 7'h0b};
  endfunction

  // Synchronous single-read-port VRF model; reg 3 starts at 0x10.. for the accumulator.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NR; i++) vrf_mem[i] <= (i == 3) ? fill(8'h10) : fill(8'(i));
    end else begin
      if (bus.vrf_ren) bus.vrf_rdata <= vrf_mem[bus.vrf_raddr];
      if (bus.vrf_we) vrf_mem[bus.vrf_waddr] <= bus.vrf_wdata;
    end
    if (bus.vrf_we) we_count <= we_count + 1;
    if (bus.done_valid) done_count <= done_count + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    bus.exe_req_ready    = 1'b0;
    bus.exe_rsp_valid    = 1'b0;
    bus.exe_rsp_id       = '0;
    bus.exe_rsp_vd_addr  = '0;
    bus.exe_rsp_vd_data  = '0;
    bus.exe_rsp_vd_write = 1'b0;
  endtask

  task automatic drive_rsp(input logic [3:0] id, input logic [4:0] addr, input logic [VW-1:0] data, input logic wr);
    bus.exe_rsp_valid    = 1'b1;
    bus.exe_rsp_id       = id;
    bus.exe_rsp_vd_addr  = addr;
    bus.exe_rsp_vd_data  = data;
    bus.exe_rsp_vd_write = wr;
  endtask

  // Called in the IDLE cycle (cycle 0); returns in cycle 1 (RD0).
  task automatic issue(input logic [3:0] id, input logic [31:0] instr);
    bus.issue_valid = 1'b1;
    bus.issue_id    = id;
    bus.issue_instr = instr;
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    preload = 1'b1;
    bus.issue_valid = 1'b0;
    bus.issue_id = '0;
    bus.issue_instr = '0;
    slave_idle();
    repeat (3) tick();
    checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_issue_ready got %b exp 0", bus.issue_ready); end
    checks++; if ({bus.vrf_ren, bus.vrf_we, bus.exe_req_valid, bus.exe_rsp_ready, bus.done_valid} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_valids got %b exp 00000", {bus.vrf_ren, bus.vrf_we, bus.exe_req_valid, bus.exe_rsp_ready, bus.done_valid});
    end
    checks++; if (bus.id_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_err got %b exp 0", bus.id_err); end
    checks++; if ({bus.vrf_raddr, bus.vrf_waddr, bus.exe_req_id, bus.done_id} !== '0) begin errors++; $display("[TB] FAIL reset_addr_id got nonzero exp 0"); end
    checks++; if (bus.exe_req_vs0 !== '0) begin errors++; $display("[TB] FAIL reset_vs0 got %h exp 0", bus.exe_req_vs0); end
    rstn = 1'b1;
    preload = 1'b0;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_issue_ready got %b exp 1", bus.issue_ready); end
  endtask

  task automatic test_basic();
    logic [4:0] exp_raddr [3] = '{5'd1, 5'd2, 5'd3};
    issue(4'd5, mk(5'd1, 5'd2, 5'd3));
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.vrf_ren !== 1'b1 || bus.vrf_raddr !== exp_raddr[c]) begin
        errors++; $display("[TB] FAIL basic_raddr_c%0d got ren=%b addr=%0d exp ren=1 addr=%0d", c + 1, bus.vrf_ren, bus.vrf_raddr, exp_raddr[c]);
      end
      if (c == 0) begin
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_ready got %b exp 0", bus.issue_ready); end
      end
      tick();
    end
    checks++; if (bus.exe_req_valid !== 1'b0 || bus.vrf_ren !== 1'b0) begin errors++; $display("[TB] FAIL basic_c4 got req=%b ren=%b exp 0 0", bus.exe_req_valid, bus.vrf_ren); end
    tick();
    checks++; if (bus.exe_req_valid !== 1'b1 || bus.exe_rsp_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_c5_valid got req=%b rsp_rdy=%b exp 1 1", bus.exe_req_valid, bus.exe_rsp_ready); end
    checks++; if (bus.exe_req_vs0 !== fill(8'h01)) begin errors++; $display("[TB] FAIL basic_vs0 got %h exp %h", bus.exe_req_vs0, fill(8'h01)); end
    checks++; if (bus.exe_req_vs1 !== fill(8'h02)) begin errors++; $display("[TB] FAIL basic_vs1 got %h exp %h", bus.exe_req_vs1, fill(8'h02)); end
    checks++; if (bus.exe_req_vs2 !== fill(8'h10)) begin errors++; $display("[TB] FAIL basic_vs2 got %h exp %h", bus.exe_req_vs2, fill(8'h10)); end
    checks++; if (bus.exe_req_id !== 4'd5 || bus.exe_req_instr !== mk(5'd1, 5'd2, 5'd3)) begin
      errors++; $display("[TB] FAIL basic_req_tag got id=%0d instr=%h exp 5 %h", bus.exe_req_id, bus.exe_req_instr, mk(5'd1, 5'd2, 5'd3));
    end
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd5, 5'd3, fill(8'hAA), 1'b1);
    tick();
    checks++; if (bus.vrf_we !== 1'b1 || bus.vrf_waddr !== 5'd3 || bus.vrf_wdata !== fill(8'hAA)) begin
      errors++; $display("[TB] FAIL basic_wb got we=%b addr=%0d data=%h exp 1 3 %h", bus.vrf_we, bus.vrf_waddr, bus.vrf_wdata, fill(8'hAA));
    end
    checks++; if (bus.done_valid !== 1'b1 || bus.done_id !== 4'd5) begin errors++; $display("[TB] FAIL basic_done got v=%b id=%0d exp 1 5", bus.done_valid, bus.done_id); end
    slave_idle();
    tick();
    checks++; if (bus.issue_ready !== 1'b1 || bus.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_c7 got ready=%b done=%b exp 1 0", bus.issue_ready, bus.done_valid); end
    checks++; if (vrf_mem[3] !== fill(8'hAA)) begin errors++; $display("[TB] FAIL basic_vrf3 got %h exp %h", vrf_mem[3], fill(8'hAA)); end
  endtask

  task automatic test_req_stall();
    issue(4'd1, mk(5'd2, 5'd1, 5'd4));
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.exe_req_valid !== 1'b1 || bus.exe_req_vs0 !== fill(8'h02) || bus.exe_req_vs1 !== fill(8'h01) ||
                    bus.exe_req_vs2 !== fill(8'h04) || bus.exe_req_id !== 4'd1) begin
        errors++; $display("[TB] FAIL stall_hold_%0d got v=%b id=%0d vs0=%h exp 1 1 %h", k, bus.exe_req_valid, bus.exe_req_id, bus.exe_req_vs0, fill(8'h02));
      end
      tick();
    end
    checks++; if (bus.exe_req_valid !== 1'b1 || bus.done_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_c8 got req=%b done=%b exp 1 0", bus.exe_req_valid, bus.done_valid); end
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd1, 5'd4, fill(8'h55), 1'b1);
    tick();
    checks++; if (bus.done_valid !== 1'b1 || bus.vrf_we !== 1'b1 || bus.vrf_waddr !== 5'd4) begin
      errors++; $display("[TB] FAIL stall_wb got done=%b we=%b addr=%0d exp 1 1 4", bus.done_valid, bus.vrf_we, bus.vrf_waddr);
    end
`ifdef XADAC_VRF_SEQ_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stall_perf got %0d exp 3", perf_stall_cnt); end
`endif
    slave_idle();
    tick();
    checks++; if (vrf_mem[4] !== fill(8'h55)) begin errors++; $display("[TB] FAIL stall_vrf4 got %h exp %h", vrf_mem[4], fill(8'h55)); end
  endtask

  task automatic test_rsp_delay();
    issue(4'd2, mk(5'd3, 5'd4, 5'd5));
    repeat (4) tick();
    checks++; if (bus.exe_req_vs0 !== fill(8'hAA) || bus.exe_req_vs1 !== fill(8'h55)) begin
      errors++; $display("[TB] FAIL delay_raw got vs0=%h vs1=%h exp %h %h", bus.exe_req_vs0, bus.exe_req_vs1, fill(8'hAA), fill(8'h55));
    end
    bus.exe_req_ready = 1'b1;
    tick();
    bus.exe_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (bus.exe_req_valid !== 1'b0 || bus.exe_rsp_ready !== 1'b1 || bus.done_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL delay_rsp_c%0d got req=%b rdy=%b done=%b exp 0 1 0", k + 6, bus.exe_req_valid, bus.exe_rsp_ready, bus.done_valid);
      end
      tick();
    end
    drive_rsp(4'd2, 5'd5, fill(8'h33), 1'b1);
    tick();
    checks++; if (bus.done_valid !== 1'b1 || bus.done_id !== 4'd2 || bus.vrf_we !== 1'b1) begin
      errors++; $display("[TB] FAIL delay_wb got done=%b id=%0d we=%b exp 1 2 1", bus.done_valid, bus.done_id, bus.vrf_we);
    end
    slave_idle();
    tick();
`ifdef XADAC_VRF_SEQ_PERF_EN
    checks++; if (perf_stall_cnt !== 32'd6 || perf_instr_cnt !== 32'd3) begin
      errors++; $display("[TB] FAIL delay_perf got stall=%0d instr=%0d exp 6 3", perf_stall_cnt, perf_instr_cnt);
    end
`endif
    checks++; if (vrf_mem[5] !== fill(8'h33)) begin errors++; $display("[TB] FAIL delay_vrf5 got %h exp %h", vrf_mem[5], fill(8'h33)); end
  endtask

  task automatic test_no_write();
    int we0;
    we0 = we_count;
    issue(4'd3, mk(5'd1, 5'd1, 5'd2));
    repeat (4) tick();
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd3, 5'd2, fill(8'hFF), 1'b0);
    tick();
    checks++; if (bus.vrf_we !== 1'b0 || bus.done_valid !== 1'b1 || bus.done_id !== 4'd3) begin
      errors++; $display("[TB] FAIL nowr_wb got we=%b done=%b id=%0d exp 0 1 3", bus.vrf_we, bus.done_valid, bus.done_id);
    end
    slave_idle();
    tick();
    checks++; if (vrf_mem[2] !== fill(8'h02) || we_count !== we0) begin
      errors++; $display("[TB] FAIL nowr_vrf2 got %h writes=%0d exp %h %0d", vrf_mem[2], we_count, fill(8'h02), we0);
    end
  endtask

  task automatic test_id_err();
    issue(4'd5, mk(5'd1, 5'd2, 5'd6));
    repeat (4) tick();
    checks++; if (bus.id_err !== 1'b0) begin errors++; $display("[TB] FAIL iderr_pre got %b exp 0", bus.id_err); end
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd6, 5'd6, fill(8'h66), 1'b1);
    tick();
    checks++; if (bus.id_err !== 1'b1 || bus.done_valid !== 1'b1 || bus.vrf_we !== 1'b1) begin
      errors++; $display("[TB] FAIL iderr_set got err=%b done=%b we=%b exp 1 1 1", bus.id_err, bus.done_valid, bus.vrf_we);
    end
    slave_idle();
    tick();
    checks++; if (vrf_mem[6] !== fill(8'h66)) begin errors++; $display("[TB] FAIL iderr_vrf6 got %h exp %h", vrf_mem[6], fill(8'h66)); end
    issue(4'd7, mk(5'd1, 5'd2, 5'd7));
    repeat (4) tick();
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd7, 5'd7, fill(8'h77), 1'b1);
    tick();
    checks++; if (bus.id_err !== 1'b1 || bus.done_id !== 4'd7) begin
      errors++; $display("[TB] FAIL iderr_sticky got err=%b id=%0d exp 1 7", bus.id_err, bus.done_id);
    end
    slave_idle();
    tick();
    rstn = 1'b0;
    tick();
    checks++; if (bus.id_err !== 1'b0) begin errors++; $display("[TB] FAIL iderr_clear got %b exp 0", bus.id_err); end
    rstn = 1'b1;
  endtask

  task automatic test_mid_reset();
    int we0;
    int d0;
    we0 = we_count;
    d0 = done_count;
    issue(4'd8, mk(5'd1, 5'd2, 5'd3));
    tick();
    tick();
    rstn = 1'b0;
    tick();
    checks++; if (bus.vrf_ren !== 1'b0 || bus.exe_req_valid !== 1'b0 || bus.issue_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_c4 got ren=%b req=%b ready=%b exp 0 0 0", bus.vrf_ren, bus.exe_req_valid, bus.issue_ready);
    end
    rstn = 1'b1;
    #1;
    checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_idle got %b exp 1", bus.issue_ready); end
    repeat (6) tick();
    checks++; if (we_count !== we0 || done_count !== d0) begin
      errors++; $display("[TB] FAIL midrst_dropped got writes=%0d dones=%0d exp %0d %0d", we_count, done_count, we0, d0);
    end
    issue(4'd9, mk(5'd2, 5'd1, 5'd8));
    repeat (4) tick();
    checks++; if (bus.exe_req_valid !== 1'b1 || bus.exe_req_vs0 !== fill(8'h02) || bus.exe_req_vs1 !== fill(8'h01)) begin
      errors++; $display("[TB] FAIL midrst_new_req got v=%b vs0=%h exp 1 %h", bus.exe_req_valid, bus.exe_req_vs0, fill(8'h02));
    end
    bus.exe_req_ready = 1'b1;
    drive_rsp(4'd9, 5'd8, fill(8'h99), 1'b1);
    tick();
    checks++; if (bus.done_valid !== 1'b1 || bus.done_id !== 4'd9) begin errors++; $display("[TB] FAIL midrst_done got v=%b id=%0d exp 1 9", bus.done_valid, bus.done_id); end
    slave_idle();
    tick();
    checks++; if (vrf_mem[8] !== fill(8'h99) || bus.id_err !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_vrf8 got %h err=%b exp %h 0", vrf_mem[8], bus.id_err, fill(8'h99));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_stall();
    test_rsp_delay();
    test_no_write();
    test_id_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
